demux_word_serializer: RTL and testbench



---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_bit_counter.sv | 39 +++
 rtl/demux_word_serializer.sv | 141 ++++++++++++++
 tb/tb_demux_word_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux word serializer: state encoding,
// channel width and default word/gap sizing.
package demux_pkg;

    localparam int CHAN_W        = 2;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/demux_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module demux_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over a decrement.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/demux_word_serializer.sv
// Serializes a parallel word MSB first onto d with the channel held on s,
// followed by an optional idle gap so downstream collectors can frame words.
module demux_word_serializer
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CHAN_W-1:0] in_chan,
    output logic              d,
    output logic [CHAN_W-1:0] s,
    output logic              frame,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = 4;
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : {GAP_W{1'b0}};
    localparam bit HAS_GAP = (GAP > 0);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic                d_q, d_d;
    logic [CHAN_W-1:0]   s_q, s_d;
    logic                frame_q, frame_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_load_s, bit_dec_s, bit_zero_s;
    logic                gap_load_s, gap_dec_s, gap_zero_s;

    demux_bit_counter #(.W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bit_load_s),
        .load_val (BIT_LOAD),
        .dec      (bit_dec_s),
        .zero     (bit_zero_s)
    );

    demux_bit_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load_s),
        .load_val (GAP_LOAD),
        .dec      (gap_dec_s),
        .zero     (gap_zero_s)
    );

    // Next-state and next-output logic; in_data is only sampled on a handshake
    // so unknowns on an idle bus never reach d.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        d_d        = 1'b0;
        s_d        = s_q;
        frame_d    = 1'b0;
        done_d     = 1'b0;
        bit_load_s = 1'b0;
        bit_dec_s  = 1'b0;
        gap_load_s = 1'b0;
        gap_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_SHIFT;
                    shift_d    = {in_data[WIDTH-2:0], 1'b0};
                    d_d        = in_data[WIDTH-1];
                    s_d        = in_chan;
                    frame_d    = 1'b1;
                    bit_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Counter at zero means the last bit is currently on d.
                if (bit_zero_s) begin
                    done_d = 1'b1;
                    if (HAS_GAP) begin
                        state_d    = ST_GAP;
                        gap_load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    d_d       = shift_q[WIDTH-1];
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    frame_d   = 1'b1;
                    bit_dec_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= {WIDTH{1'b0}};
            d_q     <= 1'b0;
            s_q     <= {CHAN_W{1'b0}};
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            d_q     <= d_d;
            s_q     <= s_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign d        = d_q;
    assign s        = s_q;
    assign frame    = frame_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_demux_word_serializer.sv
// Self-checking bench: four serializer configurations driven by directed
// scenarios and a randomized per-channel word scoreboard.
module tb_demux_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  d_v;
    logic [3:0]  frame_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [31:0] din  [4];
    logic [1:0]  chan [4];
    logic [1:0]  s_v  [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [31:0] q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_word_serializer #(.WIDTH(8), .GAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(din[0][7:0]), .in_chan(chan[0]), .d(d_v[0]), .s(s_v[0]),
        .frame(frame_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    demux_word_serializer #(.WIDTH(8), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(din[1][7:0]), .in_chan(chan[1]), .d(d_v[1]), .s(s_v[1]),
        .frame(frame_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    demux_word_serializer #(.WIDTH(2), .GAP(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(din[2][1:0]), .in_chan(chan[2]), .d(d_v[2]), .s(s_v[2]),
        .frame(frame_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    demux_word_serializer #(.WIDTH(32), .GAP(15)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(din[3]), .in_chan(chan[3]), .d(d_v[3]), .s(s_v[3]),
        .frame(frame_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({d_v[k], s_v[k], frame_v[k], busy_v[k], done_v[k], in_ready[k]} !== 7'b0000001) begin
                failures++;
                $display("FAIL reset_state inst%0d got=%b expected=0000001", k,
                         {d_v[k], s_v[k], frame_v[k], busy_v[k], done_v[k], in_ready[k]});
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        in_valid[0] = 1'b1; din[0] = 32'h0000_00A5; chan[0] = 2'd2;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({frame_v[0], s_v[0], d_v[0], busy_v[0], done_v[0]} !== {1'b1, 2'd2, w[7-i], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL single_bit%0d got={frame,s,d,busy,done}=%b expected=%b", i,
                         {frame_v[0], s_v[0], d_v[0], busy_v[0], done_v[0]}, {1'b1, 2'd2, w[7-i], 1'b1, 1'b0});
            end
            tick();
        end
        checks++;
        if ({frame_v[0], d_v[0], done_v[0], busy_v[0], in_ready[0]} !== 5'b00110) begin
            failures++;
            $display("FAIL single_done got={frame,d,done,busy,ready}=%b expected=00110",
                     {frame_v[0], d_v[0], done_v[0], busy_v[0], in_ready[0]});
        end
        tick();
        checks++;
        if ({done_v[0], busy_v[0], in_ready[0]} !== 3'b001) begin
            failures++;
            $display("FAIL single_idle got={done,busy,ready}=%b expected=001",
                     {done_v[0], busy_v[0], in_ready[0]});
        end
    endtask

    // Holds in_valid across two words and records what appears on the serial side.
    task automatic run_pair(input int k, input logic [31:0] w0, input logic [1:0] c0,
                            input logic [31:0] w1, input logic [1:0] c1,
                            output int dt, output logic [31:0] ow0, output logic [31:0] ow1,
                            output logic [1:0] oc0, output logic [1:0] oc1, output bit sbad,
                            output int low, output int hs1, output int done1);
        int nw, nhs, lowc;
        int tf [2];
        logic [31:0] acc;
        logic [1:0]  cur;
        bit pf;
        nw = 0; nhs = 0; lowc = 0; acc = 32'd0; cur = 2'd0; pf = 1'b0;
        tf[0] = 0; tf[1] = 0;
        dt = -1; ow0 = 32'd0; ow1 = 32'd0; oc0 = 2'd0; oc1 = 2'd0;
        sbad = 1'b0; low = -1; hs1 = -1; done1 = -1;
        in_valid[k] = 1'b1; din[k] = w0; chan[k] = c0;
        for (int t = 0; t < 60 && nw < 2; t++) begin
            if (in_valid[k] && in_ready[k]) begin
                if (nhs == 1) hs1 = cyc;
                nhs++;
            end
            if (done_v[k] && done1 < 0) done1 = cyc;
            if (frame_v[k]) begin
                if (!pf) begin
                    tf[nw] = cyc;
                    cur = s_v[k];
                    acc = 32'd0;
                    if (nw == 0) begin
                        din[k] = w1; chan[k] = c1;
                    end else begin
                        in_valid[k] = 1'b0;
                        low = lowc;
                    end
                end
                if (s_v[k] !== cur) sbad = 1'b1;
                acc = {acc[30:0], d_v[k]};
            end else begin
                if (pf) begin
                    if (nw == 0) begin ow0 = acc; oc0 = cur; end
                    else begin ow1 = acc; oc1 = cur; end
                    nw++;
                end
                if (nw == 1) lowc++;
            end
            pf = frame_v[k];
            tick();
        end
        in_valid[k] = 1'b0;
        if (nw == 2) dt = tf[1] - tf[0];
    endtask

    task automatic test_back_to_back();
        int dt, low, hs1, done1;
        logic [31:0] w0, w1;
        logic [1:0] c0, c1;
        bit sbad;
        run_pair(0, 32'h0000_00FF, 2'd0, 32'h0000_0001, 2'd3, dt, w0, w1, c0, c1, sbad, low, hs1, done1);
        checks++;
        if (dt !== 10) begin failures++; $display("FAIL b2b_period got=%0d expected=10", dt); end
        checks++;
        if ({w0, c0, w1, c1} !== {32'h0000_00FF, 2'd0, 32'h0000_0001, 2'd3}) begin
            failures++;
            $display("FAIL b2b_words got=%h/%0d %h/%0d expected=ff/0 01/3", w0, c0, w1, c1);
        end
        checks++;
        if (sbad !== 1'b0) begin failures++; $display("FAIL b2b_s_stable got=1 expected=0"); end
        repeat (4) tick();
    endtask

    task automatic test_gap0();
        int dt, low, hs1, done1;
        logic [31:0] w0, w1;
        logic [1:0] c0, c1;
        bit sbad;
        run_pair(1, 32'h0000_0080, 2'd1, 32'h0000_007F, 2'd1, dt, w0, w1, c0, c1, sbad, low, hs1, done1);
        checks++;
        if (dt !== 9) begin failures++; $display("FAIL gap0_period got=%0d expected=9", dt); end
        checks++;
        if (hs1 < 0 || hs1 !== done1) begin
            failures++;
            $display("FAIL gap0_hs_in_done got=hs@%0d expected=done@%0d", hs1, done1);
        end
        checks++;
        if (low !== 1) begin failures++; $display("FAIL gap0_frame_low got=%0d expected=1", low); end
        checks++;
        if ({w0, c0, w1, c1} !== {32'h0000_0080, 2'd1, 32'h0000_007F, 2'd1}) begin
            failures++;
            $display("FAIL gap0_words got=%h/%0d %h/%0d expected=80/1 7f/1", w0, c0, w1, c1);
        end
        repeat (4) tick();
    endtask

    task automatic test_busy_ignore();
        logic [7:0] acc;
        int extra;
        acc = 8'd0; extra = 0;
        in_valid[0] = 1'b1; din[0] = 32'h0000_0011; chan[0] = 2'd1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({in_ready[0], frame_v[0], s_v[0]} !== 4'b0101) begin
                failures++;
                $display("FAIL busy_hold%0d got={ready,frame,s}=%b expected=0101", i,
                         {in_ready[0], frame_v[0], s_v[0]});
            end
            acc = {acc[6:0], d_v[0]};
            in_valid[0] = ~in_valid[0];
            din[0] = 32'h0000_0022; chan[0] = 2'd0;
            tick();
        end
        in_valid[0] = 1'b0;
        checks++;
        if (acc !== 8'h11) begin failures++; $display("FAIL busy_word got=%h expected=11", acc); end
        repeat (12) begin
            if (frame_v[0]) extra++;
            tick();
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL busy_accepted got=%0d frame cycles expected=0", extra); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] acc;
        bit dp, sb;
        acc = 8'd0; dp = 1'b0; sb = 1'b0;
        in_valid[0] = 1'b1; din[0] = 32'h0000_00C3; chan[0] = 2'd2;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_v[0], s_v[0], frame_v[0], busy_v[0], done_v[0], in_ready[0]} !== 7'b0000001) begin
            failures++;
            $display("FAIL midword_reset got=%b expected=0000001",
                     {d_v[0], s_v[0], frame_v[0], busy_v[0], done_v[0], in_ready[0]});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            if (done_v[0] || frame_v[0]) dp = 1'b1;
            tick();
        end
        checks++;
        if (dp !== 1'b0) begin failures++; $display("FAIL midword_no_done got=1 expected=0"); end
        in_valid[0] = 1'b1; din[0] = 32'h0000_003C; chan[0] = 2'd1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (frame_v[0] !== 1'b1 || s_v[0] !== 2'd1) sb = 1'b1;
            acc = {acc[6:0], d_v[0]};
            tick();
        end
        checks++;
        if (acc !== 8'h3C || sb !== 1'b0) begin
            failures++;
            $display("FAIL midword_restart got=%h sel_err=%0d expected=3c sel_err=0", acc, sb);
        end
        repeat (4) tick();
    endtask

    task automatic test_sweep(input int k, input int w, input int g, input int n);
        logic [63:0] m64;
        logic [31:0] mask;
        int rx;
        m64  = (64'd1 << w) - 64'd1;
        mask = m64[31:0];
        rx   = 0;
        for (int c = 0; c < 4; c++) q[c].delete();
        fork
            begin : drv
                for (int i = 0; i < n; i++) begin
                    int idle, wt;
                    logic [31:0] wd;
                    logic [1:0]  cd;
                    idle = int'($urandom_range(2, 0));
                    wd = $urandom & mask;
                    cd = 2'($urandom_range(3, 0));
                    wt = 0;
                    repeat (idle) tick();
                    din[k] = wd; chan[k] = cd; in_valid[k] = 1'b1;
                    while (!in_ready[k] && wt < 400) begin
                        tick();
                        wt++;
                    end
                    q[cd].push_back(wd);
                    tick();
                    in_valid[k] = 1'b0;
                    din[k] = 32'hXXXX_XXXX;
                end
            end
            begin : mon
                int budget, nb;
                logic [31:0] acc, e;
                logic [1:0]  cur;
                bit pf, sb;
                budget = n * (w + g + 4) + 200;
                nb = 0; acc = 32'd0; cur = 2'd0; pf = 1'b0; sb = 1'b0;
                for (int t = 0; t < budget && rx < n; t++) begin
                    if (frame_v[k]) begin
                        if (!pf) begin acc = 32'd0; nb = 0; cur = s_v[k]; sb = 1'b0; end
                        if (s_v[k] !== cur) sb = 1'b1;
                        acc = {acc[30:0], d_v[k]};
                        nb++;
                    end else if (pf) begin
                        rx++;
                        checks++;
                        if (q[cur].size() == 0) begin
                            failures++;
                            $display("FAIL sweep_w%0d_unexpected got=%h on ch%0d expected=no word", w, acc, cur);
                        end else begin
                            e = q[cur].pop_front();
                            if (acc !== e || nb != w || sb) begin
                                failures++;
                                $display("FAIL sweep_w%0d_word got=%h bits=%0d sel_err=%0d expected=%h bits=%0d ch%0d",
                                         w, acc, nb, sb, e, w, cur);
                            end
                        end
                    end
                    pf = frame_v[k];
                    tick();
                end
                if (rx < n) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_w%0d_timeout got=%0d words expected=%0d", w, rx, n);
                end
            end
        join
        repeat (50) tick();
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            din[k]  = 32'd0;
            chan[k] = 2'd0;
        end
        #2;
        test_reset();
        test_single();
        repeat (3) tick();
        test_back_to_back();
        test_gap0();
        test_busy_ignore();
        test_reset_midword();
        test_sweep(2, 2, 0, 1000);
        test_sweep(3, 32, 15, 600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
